counter_adv: RTL

COUNTER_ADV -- requirements
Module: counter_adv

---
 rtl/counter_adv.sv | 128 ++++++++++++
 1 files changed

// File: rtl/counter_adv.sv
// Up/down counter with WRAP, SATURATE and ONESHOT overrun handling.
// Optional load path is compiled in only when COUNTER_ADV_LOAD_EN is defined.
module counter_adv #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned COUNT_FROM = 0,
  parameter int unsigned COUNT_TO   = 255,
  parameter int unsigned STEP       = 1,
  parameter string       MODE       = "WRAP"
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  dir,
  input  logic                  clr,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] load_value,
  output logic [DATA_WIDTH-1:0] out,
  output logic                  tc,
  output logic                  done
);

  localparam bit IS_SAT = (MODE == "SATURATE");
  localparam bit IS_ONE = (MODE == "ONESHOT");

  localparam logic [DATA_WIDTH-1:0] FROM_V = DATA_WIDTH'(COUNT_FROM);
  localparam logic [DATA_WIDTH-1:0] TO_V   = DATA_WIDTH'(COUNT_TO);
  localparam logic [DATA_WIDTH:0]   STEP_X = (DATA_WIDTH+1)'(STEP);
  localparam logic [DATA_WIDTH:0]   FROM_X = {1'b0, FROM_V};
  localparam logic [DATA_WIDTH:0]   TO_X   = {1'b0, TO_V};

  logic [1:0]            sync_q;
  logic                  run;
  logic [DATA_WIDTH-1:0] out_q, out_d;
  logic                  tc_q, tc_d;
  logic                  done_q, done_d;
  logic                  sat_q, sat_d;

  logic        [DATA_WIDTH:0]   up_next;
  logic signed [DATA_WIDTH:0]   dn_next;
  logic                         overrun;
  logic        [DATA_WIDTH-1:0] step_val;
  logic        [DATA_WIDTH-1:0] bound_dir;
  logic        [DATA_WIDTH-1:0] bound_opp;

  // Release is taken from the first stage so counting resumes on the second edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sync_q <= 2'b00;
    else      sync_q <= {sync_q[0], 1'b1};
  end

  assign run = sync_q[0] | sync_q[1];

  assign up_next   = {1'b0, out_q} + STEP_X;
  assign dn_next   = $signed({1'b0, out_q}) - $signed(STEP_X);
  assign overrun   = dir ? (dn_next < $signed(FROM_X)) : (up_next > TO_X);
  assign step_val  = dir ? dn_next[DATA_WIDTH-1:0] : up_next[DATA_WIDTH-1:0];
  assign bound_dir = dir ? FROM_V : TO_V;
  assign bound_opp = dir ? TO_V : FROM_V;

`ifdef COUNTER_ADV_LOAD_EN
  logic [DATA_WIDTH-1:0] load_clamped;

  always_comb begin
    load_clamped = load_value;
    if (load_value < FROM_V)    load_clamped = FROM_V;
    else if (load_value > TO_V) load_clamped = TO_V;
  end
`else
  logic load_unused;
  assign load_unused = ^{load, load_value};
`endif

  // sat_q marks a saturated run so repeated overruns at the same bound stay silent.
  always_comb begin
    out_d  = out_q;
    tc_d   = 1'b0;
    done_d = done_q;
    sat_d  = sat_q;
    if (!run) begin
      out_d = out_q;
    end else if (clr) begin
      out_d  = bound_opp;
      done_d = 1'b0;
      sat_d  = 1'b0;
`ifdef COUNTER_ADV_LOAD_EN
    end else if (load) begin
      out_d  = load_clamped;
      done_d = 1'b0;
      sat_d  = 1'b0;
`endif
    end else if (en && !(IS_ONE && done_q)) begin
      if (!overrun) begin
        out_d = step_val;
        sat_d = 1'b0;
      end else if (IS_SAT) begin
        out_d = bound_dir;
        tc_d  = !(sat_q && (out_q == bound_dir));
        sat_d = 1'b1;
      end else if (IS_ONE) begin
        out_d  = bound_dir;
        tc_d   = 1'b1;
        done_d = 1'b1;
      end else begin
        out_d = bound_opp;
        tc_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_q  <= FROM_V;
      tc_q   <= 1'b0;
      done_q <= 1'b0;
      sat_q  <= 1'b0;
    end else begin
      out_q  <= out_d;
      tc_q   <= tc_d;
      done_q <= done_d;
      sat_q  <= sat_d;
    end
  end

  assign out  = out_q;
  assign tc   = tc_q;
  assign done = done_q;

endmodule
